// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - bus structs and memory-transaction constants shared by the arbiter
package mem_bus_arbiter_pkg;

    typedef logic [2:0] msize_t;
    localparam msize_t MSIZE1 = 3'b000;
    localparam msize_t MSIZE2 = 3'b001;
    localparam msize_t MSIZE4 = 3'b010;
    localparam msize_t MSIZE8 = 3'b011;

    typedef logic [3:0] mlen_t;
    localparam mlen_t MLEN1 = 4'b0000;

    typedef logic [1:0] axi_burst_type_t;
    localparam axi_burst_type_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_type_t AXI_BURST_INCR  = 2'b01;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        logic [63:0]     addr;
        logic [7:0]      strobe;
        logic [63:0]     data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    // Instruction words are 32 bits; addr[2] picks the half of the 64-bit bus beat.
    function automatic logic [31:0] ibus_select(input logic hi, input logic [63:0] beat);
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_cbus_req_gen.sv
// rtl/mem_bus_arbiter_cbus_req_gen.sv - builds the single-beat cbus request from the latched port request
module cbus_req_gen
    import mem_bus_arbiter_pkg::*;
(
    input  logic      busy,
    input  logic      sel_d,
    input  ibus_req_t ireq_q,
    input  dbus_req_t dreq_q,
    output cbus_req_t oreq
);

    always_comb begin
        oreq = '0;
        if (busy) begin
            oreq.len   = MLEN1;
            oreq.burst = AXI_BURST_FIXED;
            if (sel_d) begin
                oreq.valid    = dreq_q.valid;
                oreq.is_write = |dreq_q.strobe;
                oreq.size     = dreq_q.size;
                oreq.addr     = dreq_q.addr;
                oreq.strobe   = dreq_q.strobe;
                oreq.data     = dreq_q.data;
            end else begin
                // Fetches always read the aligned 32-bit word.
                oreq.valid    = ireq_q.valid;
                oreq.is_write = 1'b0;
                oreq.size     = MSIZE4;
                oreq.addr     = ireq_q.addr & ~64'h3;
                oreq.strobe   = '0;
                oreq.data     = '0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - merges ibus and dbus onto one cbus, one single-beat transaction at a time
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t      state, state_nxt;
    ibus_req_t   ireq_q;
    dbus_req_t   dreq_q;
    logic        sel_d;
    logic [63:0] rdata;

    logic grant_d, grant_i, busy, done;

    assign grant_d = dreq.valid && (DATA_FIRST || !ireq.valid);
    assign grant_i = ireq.valid && !grant_d;
    assign busy    = (state == BUSY_I) || (state == BUSY_D);
    assign done    = busy && oresp.ready && oresp.last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_d)      state_nxt = BUSY_D;
                else if (grant_i) state_nxt = BUSY_I;
            end
            BUSY_I, BUSY_D: if (done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Requests are latched at grant so requester changes during BUSY are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ireq_q <= '0;
            dreq_q <= '0;
            sel_d  <= 1'b0;
            rdata  <= '0;
        end else begin
            if (state == IDLE) begin
                if (grant_d) begin
                    dreq_q <= dreq;
                    sel_d  <= 1'b1;
                end else if (grant_i) begin
                    ireq_q <= ireq;
                    sel_d  <= 1'b0;
                end
            end
            if (done) begin
                if (sel_d) rdata <= (|dreq_q.strobe) ? 64'd0 : oresp.data;
                else        rdata <= {32'd0, ibus_select(ireq_q.addr[2], oresp.data)};
            end
        end
    end

    always_comb begin
        iresp = '0;
        dresp = '0;
        if (state == RESP) begin
            if (sel_d) begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
                dresp.data    = rdata;
            end else begin
                iresp.addr_ok = 1'b1;
                iresp.data_ok = 1'b1;
                iresp.data    = rdata[31:0];
            end
        end
    end

    cbus_req_gen u_req_gen (
        .busy   (busy),
        .sel_d  (sel_d),
        .ireq_q (ireq_q),
        .dreq_q (dreq_q),
        .oreq   (oreq)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        step();
        step();
        chk("rst_oreq_valid", 128'(oreq.valid), 128'd0);
        chk("rst_iresp", 128'(iresp), 128'd0);
        chk("rst_dresp", 128'(dresp), 128'd0);

        reset = 1'b1;
        step();

        // fetch with two wait cycles
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0004;
        #1;
        chk("fetch_idle_valid", 128'(oreq.valid), 128'd0);
        step();
        chk("fetch_valid", 128'(oreq.valid), 128'd1);
        chk("fetch_addr", 128'(oreq.addr), 128'h8000_0004);
        chk("fetch_is_write", 128'(oreq.is_write), 128'd0);
        chk("fetch_size", 128'(oreq.size), 128'(MSIZE4));
        chk("fetch_strobe", 128'(oreq.strobe), 128'd0);
        chk("fetch_len", 128'(oreq.len), 128'(MLEN1));
        chk("fetch_burst", 128'(oreq.burst), 128'(AXI_BURST_FIXED));
        step();
        chk("fetch_wait_valid", 128'(oreq.valid), 128'd1);
        chk("fetch_wait_addr", 128'(oreq.addr), 128'h8000_0004);
        step();
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h1111_2222_3333_4444;
        step();
        oresp = '0;
        chk("fetch_data_ok", 128'(iresp.data_ok), 128'd1);
        chk("fetch_addr_ok", 128'(iresp.addr_ok), 128'd1);
        chk("fetch_data", 128'(iresp.data), 128'h1111_2222);
        chk("fetch_dresp_quiet", 128'(dresp), 128'd0);
        chk("fetch_resp_oreq", 128'(oreq.valid), 128'd0);
        ireq.valid = 1'b0;
        step();
        chk("fetch_data_ok_once", 128'(iresp.data_ok), 128'd0);

        // store, then hold dreq.valid through RESP
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0010;
        dreq.size   = MSIZE4;
        dreq.strobe = 8'h0F;
        dreq.data   = 64'hDEAD_BEEF;
        step();
        chk("store_valid", 128'(oreq.valid), 128'd1);
        chk("store_is_write", 128'(oreq.is_write), 128'd1);
        chk("store_strobe", 128'(oreq.strobe), 128'h0F);
        chk("store_addr", 128'(oreq.addr), 128'h8000_0010);
        chk("store_data", 128'(oreq.data), 128'hDEAD_BEEF);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h5555_5555_5555_5555;
        step();
        oresp = '0;
        chk("store_data_ok", 128'(dresp.data_ok), 128'd1);
        chk("store_rdata_zero", 128'(dresp.data), 128'd0);
        chk("store_iresp_quiet", 128'(iresp), 128'd0);
        step();
        chk("guard_idle_valid", 128'(oreq.valid), 128'd0);
        chk("store_data_ok_once", 128'(dresp.data_ok), 128'd0);
        dreq.valid = 1'b0;
        step();
        chk("guard_no_reissue", 128'(oreq.valid), 128'd0);

        // contention: dbus read wins, ibus follows two cycles after dbus data_ok
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h8000_0000;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0020;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        dreq.data   = 64'd0;
        step();
        chk("ctn_d_addr", 128'(oreq.addr), 128'h8000_0020);
        chk("ctn_d_is_write", 128'(oreq.is_write), 128'd0);
        chk("ctn_iresp_busy", 128'(iresp), 128'd0);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        oresp = '0;
        chk("ctn_d_data_ok", 128'(dresp.data_ok), 128'd1);
        chk("ctn_d_data", 128'(dresp.data), 128'hAAAA_BBBB_CCCC_DDDD);
        chk("ctn_iresp_resp", 128'(iresp), 128'd0);
        dreq.valid = 1'b0;
        step();
        chk("ctn_gap_valid", 128'(oreq.valid), 128'd0);
        step();
        chk("ctn_i_valid", 128'(oreq.valid), 128'd1);
        chk("ctn_i_addr", 128'(oreq.addr), 128'h8000_0000);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h1111_2222_3333_4444;
        step();
        oresp = '0;
        chk("ctn_i_data_ok", 128'(iresp.data_ok), 128'd1);
        chk("ctn_i_data_lo", 128'(iresp.data), 128'h3333_4444);
        ireq.valid = 1'b0;
        step();

        // ready without last keeps the transaction open; requester changes ignored
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0040;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        step();
        oresp.ready = 1'b1;
        oresp.last  = 1'b0;
        oresp.data  = 64'h99;
        dreq.addr   = 64'h1234_5678;
        step();
        chk("nolast_valid", 128'(oreq.valid), 128'd1);
        chk("nolast_addr", 128'(oreq.addr), 128'h8000_0040);
        chk("nolast_no_resp", 128'(dresp.data_ok), 128'd0);
        step();
        chk("nolast_valid2", 128'(oreq.valid), 128'd1);
        chk("nolast_addr2", 128'(oreq.addr), 128'h8000_0040);

        // asynchronous reset mid-transaction
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", 128'(oreq.valid), 128'd0);
        chk("rst_mid_dresp", 128'(dresp), 128'd0);
        dreq  = '0;
        oresp = '0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_after_no_resp", 128'(dresp.data_ok), 128'd0);
            chk("rst_after_idle", 128'(oreq.valid), 128'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
